// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem request, IF/ID register with stall buffer.
// Optional performance counters are built when PIPELINE_FETCH_PERF_EN is defined.
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        nop_output
`ifdef PIPELINE_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  // state    | meaning
  // ST_FETCH | request outstanding at req_addr
  // ST_HOLD  | stalled, one instruction parked in the buffer, no request
  // ST_DRAIN | wrong-path request still pending; its response is thrown away
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        complete;
  logic [31:0] target_pc;
  logic        ld_bubble;
  logic        ld_instr;
  logic [31:0] ld_data;
  logic [31:0] ld_pc;

  assign imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
  assign imem_addr = req_addr;
  assign complete  = imem_req && imem_rvalid;
  assign target_pc = redirect_pc & ~32'h3;

  always_comb begin
    ld_bubble = 1'b0;
    ld_instr  = 1'b0;
    ld_data   = buf_instr;
    ld_pc     = buf_pc;
    if (redirect_valid) begin
      ld_bubble = 1'b1;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!stall) begin
            if (complete) begin
              ld_instr = 1'b1;
              ld_data  = imem_rdata;
              ld_pc    = req_addr;
            end else begin
              ld_bubble = 1'b1;
            end
          end
        end
        ST_HOLD:  ld_instr  = !stall;
        ST_DRAIN: ld_bubble = !stall;
        default:  ld_bubble = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      buf_instr  <= 32'h0;
      buf_pc     <= 32'h0;
      instr_out  <= NOP_INSTR;
      pc_out     <= 32'h0;
      nop_output <= 1'b1;
    end else begin
      if (ld_bubble) begin
        instr_out  <= NOP_INSTR;
        pc_out     <= 32'h0;
        nop_output <= 1'b1;
      end else if (ld_instr) begin
        instr_out  <= ld_data;
        pc_out     <= ld_pc;
        nop_output <= 1'b0;
      end

      if (redirect_valid) begin
        pc        <= target_pc;
        buf_instr <= 32'h0;
        buf_pc    <= 32'h0;
        // A pending request cannot be withdrawn, so it must drain first.
        if ((state == ST_DRAIN) || ((state == ST_FETCH) && !complete)) begin
          state <= ST_DRAIN;
        end else begin
          req_addr <= target_pc;
          state    <= ST_FETCH;
        end
      end else begin
        case (state)
          ST_FETCH: begin
            if (complete) begin
              if (stall) begin
                buf_instr <= imem_rdata;
                buf_pc    <= req_addr;
                state     <= ST_HOLD;
              end else begin
                pc       <= req_addr + 32'd4;
                req_addr <= req_addr + 32'd4;
              end
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              pc       <= buf_pc + 32'd4;
              req_addr <= buf_pc + 32'd4;
              state    <= ST_FETCH;
            end
          end
          ST_DRAIN: begin
            if (complete) begin
              req_addr <= pc;
              state    <= ST_FETCH;
            end
          end
          default: state <= ST_FETCH;
        endcase
      end
    end
  end

`ifdef PIPELINE_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count  <= 32'h0;
      bubble_count <= 32'h0;
    end else begin
      if (ld_instr)  fetch_count  <= fetch_count + 32'd1;
      if (ld_bubble) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// Randomized bench for pipeline_fetch against a transaction-level fetch model and a wait-state memory.
// Perf counters are checked when PIPELINE_FETCH_PERF_EN is defined.
module tb_pipeline_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_I  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        nop_output;
`ifdef PIPELINE_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  pipeline_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .nop_output     (nop_output)
`ifdef PIPELINE_FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Memory: each accepted request waits a chosen number of cycles, data is a function of address.
  int  wait_lo = 0;
  int  wait_hi = 0;
  bit  mem_busy;
  int  mem_left;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Reference model: where the fetch unit should be asking, whether it is
  // discarding a wrong-path response, and what is parked while stalled.
  logic [31:0] m_addr;
  logic [31:0] m_target;
  bit          m_squash;
  bit          m_held;
  logic [31:0] m_held_instr;
  logic [31:0] m_held_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_nop;
  logic [31:0] m_fetches;
  logic [31:0] m_bubbles;

  task automatic model_reset();
    m_addr = RST_PC; m_target = RST_PC; m_squash = 0; m_held = 0;
    m_instr = NOP_I; m_pc = 32'h0; m_nop = 1;
    m_fetches = 0; m_bubbles = 0;
  endtask

  task automatic load_bubble();
    m_instr = NOP_I; m_pc = 32'h0; m_nop = 1; m_bubbles++;
  endtask

  task automatic load_instr(input logic [31:0] i, input logic [31:0] p);
    m_instr = i; m_pc = p; m_nop = 0; m_fetches++;
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rp, input bit rv);
    bit comp;
    comp = !m_held && rv;
    if (rd) begin
      load_bubble();
      if (m_squash || (!m_held && !comp)) begin
        m_squash = 1; m_target = {rp[31:2], 2'b00};
      end else begin
        m_squash = 0; m_addr = {rp[31:2], 2'b00};
      end
      m_held = 0;
    end else if (m_squash) begin
      if (comp) begin m_squash = 0; m_addr = m_target; end
      if (!st) load_bubble();
    end else if (m_held) begin
      if (!st) begin
        load_instr(m_held_instr, m_held_pc);
        m_addr = m_held_pc + 4;
        m_held = 0;
      end
    end else if (comp) begin
      if (st) begin
        m_held = 1; m_held_instr = mem_word(m_addr); m_held_pc = m_addr;
      end else begin
        load_instr(mem_word(m_addr), m_addr);
        m_addr = m_addr + 4;
      end
    end else if (!st) begin
      load_bubble();
    end
  endtask

  // One clock: check DUT against model at negedge, then drive the next inputs.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rp);
    @(negedge clk);
    check("instr_out", instr_out, m_instr);
    check("pc_out", pc_out, m_pc);
    check("nop_output", {31'h0, nop_output}, {31'h0, m_nop});
    check("imem_req", {31'h0, imem_req}, {31'h0, !m_held});
    if (!m_held) check("imem_addr", imem_addr, m_addr);
`ifdef PIPELINE_FETCH_PERF_EN
    check("fetch_count", fetch_count, m_fetches);
    check("bubble_count", bubble_count, m_bubbles);
`endif
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_left = $urandom_range(wait_hi, wait_lo);
      end
      imem_rvalid = (mem_left == 0);
      imem_rdata  = imem_rvalid ? mem_word(imem_addr) : $urandom;
      if (imem_rvalid) mem_busy = 0;
      else mem_left--;
    end else begin
      mem_busy = 0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    stall = st; redirect_valid = rd; redirect_pc = rp;
    model_step(st, rd, rp, imem_rvalid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    imem_rvalid = 0; imem_rdata = 0; mem_busy = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic settle();
    wait_lo = 0; wait_hi = 0;
    repeat (4) cycle(0, 0, 0);
  endtask

  initial begin
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    imem_rvalid = 0; imem_rdata = 0; mem_busy = 0; mem_left = 0;
    model_reset();
    do_reset();

    // Zero-wait streaming from RESET_PC
    wait_lo = 0; wait_hi = 0;
    repeat (6) cycle(0, 0, 0);

    // Two wait states per fetch
    wait_lo = 2; wait_hi = 2;
    repeat (12) cycle(0, 0, 0);

    // Stall across a completion at 0x20
    settle();
    cycle(0, 1, 32'h20);
    cycle(1, 0, 0);
    @(posedge clk); #1;
    check("hold_req_low", {31'h0, imem_req}, 32'h0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    @(posedge clk); #1;
    check("release_pc", pc_out, 32'h20);
    check("next_req", imem_addr, 32'h24);
    repeat (3) cycle(0, 0, 0);

    // Redirect to 0x200 while the 0x40 fetch waits on memory
    settle();
    cycle(0, 1, 32'h40);
    wait_lo = 2; wait_hi = 2;
    cycle(0, 1, 32'h200);
    repeat (5) cycle(0, 0, 0);

    // Redirect with stall, unaligned target
    settle();
    cycle(1, 1, 32'h303);
    cycle(0, 0, 0);
    repeat (2) cycle(0, 0, 0);

    // Address wrap
    settle();
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    @(posedge clk); #1;
    check("wrap_addr", imem_addr, 32'h0);
    repeat (3) cycle(0, 0, 0);

    // Random traffic, with one reset in the middle
    wait_lo = 0; wait_hi = 2;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rp;
      bit st, rd;
      if (i == 300) begin
        do_reset();
      end
      st = ($urandom_range(3, 0) == 0);
      rd = ($urandom_range(9, 0) == 0);
      rp = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle(st, rd, rp);
    end
    cycle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
